// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: multiplexed active-low 7-segment scanner over held BCD digits.
// Define BCD_DISP_LZB_EN to enable leading-zero blanking.
module bcd_disp_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [4*DIGITS-1:0]   bcd_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  err_o
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] hold_bcd;
  logic [DIGITS-1:0]   hold_dp;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                tick;
  logic [3:0]          cur_bcd;
  logic                cur_dp;
  logic                cur_blank;
  logic                any_err;
  logic [6:0]          cur_seg;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CW'(DIV - 1));

  always_comb begin
    cur_bcd = '0;
    cur_dp  = 1'b0;
    any_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_bcd = hold_bcd[4*k +: 4];
        cur_dp  = hold_dp[k];
      end
      if (hold_bcd[4*k +: 4] > 4'd9)
        any_err = 1'b1;
    end
  end

`ifdef BCD_DISP_LZB_EN
  // lz[k]: digit k and every digit above it are zero
  logic [DIGITS-1:0] lz;

  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (hold_bcd[4*DIGITS-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--)
      lz[k] = lz[k+1] && (hold_bcd[4*k +: 4] == 4'd0);
    cur_blank = 1'b0;
    for (int k = 1; k < DIGITS; k++)
      if (idx == IW'(k))
        cur_blank = lz[k];
  end
`else
  assign cur_blank = 1'b0;
`endif

  assign cur_seg = cur_blank ? 7'h7F : decode(cur_bcd);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hold_bcd <= '0;
      hold_dp  <= '0;
    end else if (load_i) begin
      hold_bcd <= bcd_i;
      hold_dp  <= dp_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tick edge forces the blank slot between digits
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      an_o  <= '1;
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
      err_o <= 1'b0;
    end else begin
      err_o <= any_err;
      if (tick) begin
        an_o  <= '1;
        seg_o <= 7'h7F;
        dp_o  <= 1'b1;
      end else begin
        an_o  <= ~(DIGITS'(1) << idx);
        seg_o <= cur_seg;
        dp_o  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb_bcd_disp_scan: directed bench with a time-based behavioural model.
// Honours BCD_DISP_LZB_EN the same way as the design.
module tb_bcd_disp_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [15:0] bcd_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_disp_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bcd_i    (bcd_i),
    .dp_i     (dp_i),
    .load_i   (load_i),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .an_o     (an_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outputs follow from edge count since reset and the held value
  logic [6:0]  segtab [16];
  int          m_t = 0;
  int          m_ph;
  int          m_dg;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_err = 1'b0;

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  end

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_t   = 0;
      m_bcd = '0;
      m_dp  = '0;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_err = 1'b0;
    end else begin
      m_ph = m_t % DIV;
      m_dg = (m_t / DIV) % DIGITS;
      if (m_ph == DIV - 1) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = ~(4'b1 << m_dg);
        e_seg = segtab[(m_bcd >> (4 * m_dg)) & 16'hF];
`ifdef BCD_DISP_LZB_EN
        if (m_dg > 0 && (m_bcd >> (4 * m_dg)) == 16'd0)
          e_seg = 7'h7F;
`endif
        e_dp = ~m_dp[m_dg];
      end
      e_err = 1'b0;
      for (int i = 0; i < DIGITS; i++)
        if (((m_bcd >> (4 * i)) & 16'hF) > 16'd9)
          e_err = 1'b1;
      if (load_i) begin
        m_bcd = bcd_i;
        m_dp  = dp_i;
      end
      m_t++;
    end
  end

  always @(negedge clk_i) begin
    check("an", an_o, e_an);
    check("seg", seg_o, e_seg);
    check("dp", dp_o, e_dp);
    check("err", err_o, e_err);
  end

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_i  = b;
    dp_i   = d;
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic check_digit(input string nm, input int k,
                             input logic [6:0] s, input logic d);
    int n = 0;
    logic [3:0] sel = ~(4'b1 << k);
    while (an_o !== sel && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    if (an_o !== sel) begin
      check({nm, "_timeout"}, an_o, sel);
    end else begin
      check(nm, seg_o, s);
      check({nm, "_dp"}, dp_o, d);
    end
  endtask

  logic [3:0] scan_tab [16];

  initial begin
    int n;
    scan_tab = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_an", an_o, 4'hF);
    check("rst_seg", seg_o, 7'h7F);
    check("rst_dp", dp_o, 1'b1);
    check("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      check("scan_an", an_o, scan_tab[i]);
      if (scan_tab[i] != 4'hF)
        check("scan_seg", seg_o, 7'h40);
    end

    do_load(16'h9502, 4'b0100);
    @(negedge clk_i);
    check_digit("l9502_d0", 0, 7'h24, 1'b1);
    check_digit("l9502_d1", 1, 7'h40, 1'b1);
    check_digit("l9502_d2", 2, 7'h12, 1'b0);
    check_digit("l9502_d3", 3, 7'h10, 1'b1);
    check("l9502_err", err_o, 1'b0);

    do_load(16'h0A13, 4'b0000);
    check("l0a13_err_n", err_o, 1'b0);
    @(negedge clk_i);
    check("l0a13_err_n1", err_o, 1'b1);
    check_digit("l0a13_d2", 2, 7'h3F, 1'b1);
    do_load(16'h0013, 4'b0000);
    check("l0013_err_n", err_o, 1'b1);
    @(negedge clk_i);
    check("l0013_err_n1", err_o, 1'b0);

    n = 0;
    while (m_t % DIV != 1 && n < 16) begin
      @(negedge clk_i);
      n++;
    end
    do_load(16'h8888, 4'b0000);
    @(negedge clk_i);
    check("l8888_seg", seg_o, 7'h00);
    @(negedge clk_i);
    check("l8888_blank_seg", seg_o, 7'h7F);
    check("l8888_blank_an", an_o, 4'hF);

    do_load(16'h0070, 4'b0000);
    @(negedge clk_i);
`ifdef BCD_DISP_LZB_EN
    check_digit("l0070_d3", 3, 7'h7F, 1'b1);
    check_digit("l0070_d2", 2, 7'h7F, 1'b1);
    check_digit("l0070_d1", 1, 7'h78, 1'b1);
    check_digit("l0070_d0", 0, 7'h40, 1'b1);
    do_load(16'h0000, 4'b1000);
    @(negedge clk_i);
    check_digit("l0000_d3", 3, 7'h7F, 1'b0);
    check_digit("l0000_d2", 2, 7'h7F, 1'b1);
    check_digit("l0000_d1", 1, 7'h7F, 1'b1);
    check_digit("l0000_d0", 0, 7'h40, 1'b1);
`else
    check_digit("l0070_d3", 3, 7'h40, 1'b1);
    check_digit("l0070_d2", 2, 7'h40, 1'b1);
    check_digit("l0070_d1", 1, 7'h78, 1'b1);
    check_digit("l0070_d0", 0, 7'h40, 1'b1);
    do_load(16'h0000, 4'b1000);
    @(negedge clk_i);
    check_digit("l0000_d3", 3, 7'h40, 1'b0);
    check_digit("l0000_d2", 2, 7'h40, 1'b1);
    check_digit("l0000_d1", 1, 7'h40, 1'b1);
    check_digit("l0000_d0", 0, 7'h40, 1'b1);
`endif

    load_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bcd_i = 16'h1234 + 16'(i * 16'h1111);
      dp_i  = 4'(i);
      @(negedge clk_i);
    end
    load_i = 1'b0;
    repeat (6) @(negedge clk_i);

    do_load(16'h0A13, 4'b0010);
    @(negedge clk_i);
    n = 0;
    while (an_o !== 4'b1011 && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_reset_find", an_o, 4'b1011);
    #2;
    reset_ni = 1'b0;
    #1;
    check("mid_reset_an", an_o, 4'hF);
    check("mid_reset_seg", seg_o, 7'h7F);
    check("mid_reset_dp", dp_o, 1'b1);
    check("mid_reset_err", err_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    check_digit("post_rst_d0", 0, 7'h40, 1'b1);
    check_digit("post_rst_d1", 1, 7'h40, 1'b1);
    check_digit("post_rst_d2", 2, 7'h40, 1'b1);
    check_digit("post_rst_d3", 3, 7'h40, 1'b1);
    check("post_rst_err", err_o, 1'b0);
    repeat (8) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
